// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader: packs a byte stream big-endian into 32-bit words and writes   |
// | them to instruction memory while holding the CPU. Optional trailing XOR    |
// | checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int NUM_WORDS = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WCNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic              hs;
  logic              last_word;

  assign hs        = byte_valid && byte_ready;
  assign last_word = (word_cnt == WCNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Every output here is a pure decode of the state register.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (hs && byte_cnt == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (hs) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_hold = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      waddr    <= '0;
      wdata    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            waddr    <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            case (byte_cnt)
              2'd0:    wdata[31:24] <= byte_data;
              2'd1:    wdata[23:16] <= byte_data;
              2'd2:    wdata[15:8]  <= byte_data;
              default: wdata[7:0]   <= byte_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          waddr    <= waddr + ADDR_W'(4);
          word_cnt <= word_cnt + WCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of image bytes, compared against the single trailing byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 8'd0;
      err  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            csum <= 8'd0;
            err  <= 1'b0;
          end
        end
        S_LOAD:  if (hs) csum <= csum ^ byte_data;
        S_CHECK: if (hs) err <= (byte_data != csum);
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
